// File: rtl/wb_cache_arbiter.sv
// Two-master Wishbone arbiter (icache = m0, dcache = m1), round-robin on ties, owner locked for the whole cyc envelope.
// One-cycle arbitration bubble, zero-latency owned path; the waiting master stalls until the owner drops cyc, watchdog errors stalled beats.
module wb_cache_arbiter #(
    parameter int AW      = 24,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          i_clk,
    input  logic          i_rst,

    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_o_dat,
    input  logic [1:0]    m0_sel,
    input  logic          m0_4_burst,
    output logic [DW-1:0] m0_i_dat,
    output logic          m0_ack,
    output logic          m0_err,

    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_o_dat,
    input  logic [1:0]    m1_sel,
    input  logic          m1_4_burst,
    output logic [DW-1:0] m1_i_dat,
    output logic          m1_ack,
    output logic          m1_err,

    output logic          s_cyc,
    output logic          s_stb,
    output logic          s_we,
    output logic [AW-1:0] s_adr,
    output logic [DW-1:0] s_o_dat,
    output logic [1:0]    s_sel,
    output logic          s_4_burst,
    input  logic [DW-1:0] s_i_dat,
    input  logic          s_ack,
    input  logic          s_err
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWN0,
        S_OWN1
    } state_t;

    state_t         state;
    logic           last;
    logic [WDW-1:0] wd_cnt;
    logic           own_stb;
    logic           wd_fire;

    // Owner strobe is derived separately so the watchdog does not loop through the output mux.
    always_comb begin
        own_stb = 1'b0;
        case (state)
            S_OWN0:  own_stb = m0_stb;
            S_OWN1:  own_stb = m1_stb;
            default: own_stb = 1'b0;
        endcase
    end

    assign wd_fire = (wd_cnt == WDW'(TIMEOUT - 1)) & own_stb & ~s_ack & ~s_err;

    always_comb begin
        s_cyc     = 1'b0;
        s_stb     = 1'b0;
        s_we      = 1'b0;
        s_adr     = '0;
        s_o_dat   = '0;
        s_sel     = '0;
        s_4_burst = 1'b0;
        m0_ack    = 1'b0;
        m0_err    = 1'b0;
        m1_ack    = 1'b0;
        m1_err    = 1'b0;
        m0_i_dat  = s_i_dat;
        m1_i_dat  = s_i_dat;
        case (state)
            S_OWN0: begin
                s_cyc     = m0_cyc;
                s_stb     = m0_stb;
                s_we      = m0_we;
                s_adr     = m0_adr;
                s_o_dat   = m0_o_dat;
                s_sel     = m0_sel;
                s_4_burst = m0_4_burst;
                m0_ack    = s_ack;
                m0_err    = s_err | wd_fire;
            end
            S_OWN1: begin
                s_cyc     = m1_cyc;
                s_stb     = m1_stb;
                s_we      = m1_we;
                s_adr     = m1_adr;
                s_o_dat   = m1_o_dat;
                s_sel     = m1_sel;
                s_4_burst = m1_4_burst;
                m1_ack    = s_ack;
                m1_err    = s_err | wd_fire;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= S_IDLE;
            last   <= 1'b1;
            wd_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // On a tie the master not served last wins.
                    if (m0_cyc && (!m1_cyc || last)) begin
                        state <= S_OWN0;
                        last  <= 1'b0;
                    end else if (m1_cyc) begin
                        state <= S_OWN1;
                        last  <= 1'b1;
                    end
                end
                S_OWN0:  if (!m0_cyc) state <= S_IDLE;
                S_OWN1:  if (!m1_cyc) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (state == S_IDLE || s_ack || s_err || wd_fire)
                wd_cnt <= '0;
            else if (own_stb)
                wd_cnt <= wd_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_cache_arbiter.sv
// Bench for wb_cache_arbiter: directed scenarios plus a randomized phase, all checked each cycle against an owner/stall-count model.
module tb_wb_cache_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int T  = 8;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          i_rst;
    logic          m0_cyc, m0_stb, m0_we, m0_4_burst, m0_ack, m0_err;
    logic [AW-1:0] m0_adr;
    logic [DW-1:0] m0_o_dat, m0_i_dat;
    logic [1:0]    m0_sel;
    logic          m1_cyc, m1_stb, m1_we, m1_4_burst, m1_ack, m1_err;
    logic [AW-1:0] m1_adr;
    logic [DW-1:0] m1_o_dat, m1_i_dat;
    logic [1:0]    m1_sel;
    logic          s_cyc, s_stb, s_we, s_4_burst, s_ack, s_err;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_o_dat, s_i_dat;
    logic [1:0]    s_sel;

    // Slave: mode 0 acks every strobe, mode 1 answers only when told, mode 2 answers randomly.
    int   slv_mode;
    logic ack_r, err_r;
    assign s_ack = (slv_mode == 0) ? s_stb : ack_r;
    assign s_err = err_r;

    wb_cache_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(T)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_o_dat(m0_o_dat), .m0_sel(m0_sel), .m0_4_burst(m0_4_burst),
        .m0_i_dat(m0_i_dat), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_o_dat(m1_o_dat), .m1_sel(m1_sel), .m1_4_burst(m1_4_burst),
        .m1_i_dat(m1_i_dat), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_o_dat(s_o_dat), .s_sel(s_sel), .s_4_burst(s_4_burst),
        .s_i_dat(s_i_dat), .s_ack(s_ack), .s_err(s_err)
    );

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 0;

    // Reference model: who owns the bus, who was served last, how long the current beat has stalled.
    int owner = -1;
    int last_m = 1;
    int stall = 0;

    // Master behaviour: queued bursts, one active burst per master.
    typedef struct { int m; logic [AW-1:0] base; int n; logic we; } burst_t;
    typedef struct { int m; logic [AW-1:0] a; } log_t;
    burst_t        pend[$];
    log_t          ack_log[$];
    int            done_q[$];
    bit            act[2];
    int            idx[2];
    int            nb[2];
    logic [AW-1:0] base_b[2];
    logic          we_b[2];
    logic          smp_ack[2], smp_err[2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_masters();
        m0_cyc = act[0]; m0_stb = act[0]; m0_we = we_b[0];
        m0_adr = base_b[0] + AW'(idx[0]); m0_o_dat = DW'($urandom);
        m0_sel = 2'($urandom); m0_4_burst = act[0] && nb[0] == 4;
        m1_cyc = act[1]; m1_stb = act[1]; m1_we = we_b[1];
        m1_adr = base_b[1] + AW'(idx[1]); m1_o_dat = DW'($urandom);
        m1_sel = 2'($urandom); m1_4_burst = act[1] && nb[1] == 4;
    endtask

    task automatic try_start(input int m);
        for (int i = 0; i < pend.size(); i++) begin
            if (pend[i].m == m) begin
                act[m] = 1; idx[m] = 0; nb[m] = pend[i].n;
                base_b[m] = pend[i].base; we_b[m] = pend[i].we;
                pend.delete(i);
                return;
            end
        end
    endtask

    task automatic start(input int m, input logic [AW-1:0] base, input int n, input logic we);
        burst_t b;
        b.m = m; b.base = base; b.n = n; b.we = we;
        pend.push_back(b);
        if (!act[m]) try_start(m);
        drive_masters();
    endtask

    task automatic cycle();
        logic [45:0] mb0, mb1, exp_s, got_s;
        logic        mstb, mcyc, fire, rst_s;
        logic [1:0]  e0, e1;
        int          n_owner, n_last, n_stall;
        @(negedge clk);
        mb0   = {m0_cyc, m0_stb, m0_we, m0_adr, m0_o_dat, m0_sel, m0_4_burst};
        mb1   = {m1_cyc, m1_stb, m1_we, m1_adr, m1_o_dat, m1_sel, m1_4_burst};
        got_s = {s_cyc, s_stb, s_we, s_adr, s_o_dat, s_sel, s_4_burst};
        exp_s = (owner == 0) ? mb0 : (owner == 1) ? mb1 : '0;
        mstb  = (owner == 0) ? m0_stb : (owner == 1) ? m1_stb : 1'b0;
        mcyc  = (owner == 0) ? m0_cyc : (owner == 1) ? m1_cyc : 1'b0;
        fire  = (owner >= 0) && (stall == T - 1) && mstb && !s_ack && !s_err;
        e0    = (owner == 0) ? {s_ack, s_err | fire} : 2'b00;
        e1    = (owner == 1) ? {s_ack, s_err | fire} : 2'b00;
        if (chk_en) begin
            check("s_bus", 64'(got_s), 64'(exp_s));
            check("m0_term", 64'({m0_ack, m0_err}), 64'(e0));
            check("m1_term", 64'({m1_ack, m1_err}), 64'(e1));
            check("m0_rdata", 64'(m0_i_dat), 64'(s_i_dat));
            check("m1_rdata", 64'(m1_i_dat), 64'(s_i_dat));
            check("wd_cnt", 64'(dut.wd_cnt), 64'(stall));
        end
        smp_ack[0] = m0_ack; smp_err[0] = m0_err;
        smp_ack[1] = m1_ack; smp_err[1] = m1_err;
        if (m0_ack) ack_log.push_back('{0, s_adr});
        if (m1_ack) ack_log.push_back('{1, s_adr});
        rst_s   = i_rst;
        n_owner = owner; n_last = last_m; n_stall = stall;
        if (rst_s) begin
            n_owner = -1; n_last = 1; n_stall = 0;
        end else if (owner < 0) begin
            n_stall = 0;
            if (m0_cyc && m1_cyc) n_owner = (last_m == 0) ? 1 : 0;
            else if (m0_cyc)      n_owner = 0;
            else if (m1_cyc)      n_owner = 1;
            if (n_owner >= 0) n_last = n_owner;
        end else begin
            if (s_ack || s_err || fire) n_stall = 0;
            else if (mstb)              n_stall = stall + 1;
            if (!mcyc) n_owner = -1;
        end
        @(posedge clk);
        #1;
        owner = n_owner; last_m = n_last; stall = n_stall;
        if (rst_s) begin
            act[0] = 0; act[1] = 0; pend.delete();
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (act[m]) begin
                    if (smp_ack[m] || smp_err[m]) begin
                        idx[m]++;
                        if (idx[m] == nb[m]) begin
                            act[m] = 0;
                            done_q.push_back(m);
                        end
                    end
                end else begin
                    try_start(m);
                end
            end
        end
        if (slv_mode == 2) begin
            ack_r = ($urandom % 4) == 0;
            err_r = ($urandom % 32) == 0;
        end
        s_i_dat = DW'($urandom);
        drive_masters();
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (!act[0] && !act[1] && pend.size() == 0 && owner < 0) begin
                ok = 1;
                break;
            end
            cycle();
        end
        check("idle_timeout", 64'(ok), 64'd1);
    endtask

    task automatic apply_reset();
        i_rst = 1;
        cycle();
        i_rst = 0;
    endtask

    initial begin
        int nerr, err_at;
        i_rst = 1; slv_mode = 0; ack_r = 0; err_r = 0; s_i_dat = '0;
        act[0] = 0; act[1] = 0; idx[0] = 0; idx[1] = 0; nb[0] = 0; nb[1] = 0;
        base_b[0] = '0; base_b[1] = '0; we_b[0] = 0; we_b[1] = 0;
        drive_masters();
        cycle();
        chk_en = 1;
        cycle();
        i_rst = 0;
        check("rst_s_cyc", 64'(s_cyc), 64'd0);
        check("rst_wd", 64'(dut.wd_cnt), 64'd0);

        // Lone m0 4-beat burst read.
        ack_log.delete();
        start(0, 24'h000100, 4, 1'b0);
        check("t1_pre_grant", 64'(s_cyc), 64'd0);
        cycle();
        check("t1_grant", 64'(s_cyc), 64'd1);
        wait_idle(40);
        check("t1_nacks", 64'(ack_log.size()), 64'd4);
        foreach (ack_log[i]) begin
            check("t1_owner", 64'(ack_log[i].m), 64'd0);
            check("t1_adr", 64'(ack_log[i].a), 64'(24'h000100 + i));
        end

        // Continuous contention after reset: strict alternation, m0 first.
        apply_reset();
        done_q.delete();
        for (int r = 0; r < 4; r++) begin
            start(0, AW'(24'h000400 + r * 16), 2, 1'b0);
            start(1, AW'(24'h000800 + r * 16), 2, 1'b1);
        end
        wait_idle(200);
        check("t2_rounds", 64'(done_q.size()), 64'd8);
        foreach (done_q[i]) check("t2_order", 64'(done_q[i]), 64'(i % 2));

        // m1 arrives while m0 is at beat 2 of its burst.
        ack_log.delete();
        start(0, 24'h000200, 4, 1'b0);
        cycle(); cycle(); cycle();
        start(1, 24'h000300, 4, 1'b1);
        wait_idle(60);
        check("t3_nacks", 64'(ack_log.size()), 64'd8);
        foreach (ack_log[i]) begin
            check("t3_owner", 64'(ack_log[i].m), 64'(i / 4));
            check("t3_adr", 64'(ack_log[i].a),
                  64'(((i < 4) ? 24'h000200 : 24'h000300) + (i % 4)));
        end

        // Watchdog: silent slave, then an ack landing in the would-fire cycle.
        slv_mode = 1; ack_r = 0; err_r = 0;
        start(1, 24'h000500, 1, 1'b0);
        cycle();
        nerr = 0; err_at = -1;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            if (smp_err[1]) begin
                nerr++;
                if (err_at < 0) err_at = k;
            end
        end
        check("t4_err_cnt", 64'(nerr), 64'd1);
        check("t4_err_at", 64'(err_at), 64'(T));
        check("t4_wd_clr", 64'(dut.wd_cnt), 64'd0);
        start(1, 24'h000510, 1, 1'b0);
        cycle();
        for (int k = 1; k < T; k++) cycle();
        ack_r = 1;
        cycle();
        check("t4_ack_wins", 64'({smp_ack[1], smp_err[1]}), 64'b10);
        ack_r = 0;
        wait_idle(20);

        // Reset during the first beat of an m1 write, then a tie goes to m0.
        start(1, 24'h000600, 4, 1'b1);
        cycle();
        check("t5_owned", 64'(s_cyc), 64'd1);
        i_rst = 1;
        cycle();
        i_rst = 0;
        check("t5_s_cyc", 64'(s_cyc), 64'd0);
        check("t5_term", 64'({m0_ack, m0_err, m1_ack, m1_err}), 64'd0);
        slv_mode = 0;
        done_q.delete();
        start(1, 24'h000700, 1, 1'b0);
        start(0, 24'h000710, 1, 1'b0);
        wait_idle(30);
        check("t5_first", 64'(done_q[0]), 64'd0);
        check("t5_second", 64'(done_q[1]), 64'd1);

        // Random traffic with a random slave and occasional resets.
        slv_mode = 2;
        for (int c = 0; c < 1500; c++) begin
            if (($urandom % 6) == 0 && pend.size() < 4)
                start(int'($urandom % 2), AW'($urandom), int'($urandom_range(1, 4)), 1'($urandom));
            i_rst = ($urandom % 300) == 0;
            cycle();
        end
        i_rst = 0;
        slv_mode = 0; ack_r = 0; err_r = 0;
        wait_idle(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
